// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline register between processor stages: a DEPTH-entry circular
// buffer carrying opaque stage records, with valid/ready handshakes and flush.
module pipe_stage_fifo #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 2,
  parameter int AF_LEVEL = DEPTH - 1,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Status comes only from count, so in_ready never sees out_ready.
  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_AF);
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign out_data    = mem[rd_ptr];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Self-checking bench for pipe_stage_fifo: a DEPTH=2 and a DEPTH=4 instance
// checked against queue-based models, a vector table and directed sequences.
module tb_pipe_stage_fifo;

  logic        clk;
  logic        resetn;

  logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2;
  logic        full2, empty2, af2;
  logic [63:0] in_data2, out_data2;
  logic [1:0]  count2;

  logic        flush4, in_valid4, in_ready4, out_valid4, out_ready4;
  logic        full4, empty4, af4;
  logic [63:0] in_data4, out_data4;
  logic [2:0]  count4;

  int asserts = 0;
  int fails   = 0;

  logic [63:0] q2[$];
  logic [63:0] q4[$];

  typedef struct {
    bit          iv;
    bit          ordy;
    logic [63:0] data;
    int          exp_count;
    bit          exp_valid;
    logic [63:0] exp_data;
    bit          exp_full;
    bit          exp_ready;
  } vec_t;

  vec_t vecs[6];

  pipe_stage_fifo #(.WIDTH(64), .DEPTH(2)) u_d2 (
    .clk(clk), .resetn(resetn), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .count(count2), .full(full2), .empty(empty2), .almost_full(af2)
  );

  pipe_stage_fifo #(.WIDTH(64), .DEPTH(4)) u_d4 (
    .clk(clk), .resetn(resetn), .flush(flush4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .count(count4), .full(full4), .empty(empty4), .almost_full(af4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour: a bounded queue, cleared by flush, where acceptance
  // is decided by the occupancy before the edge.
  task automatic modelStep(input int sel, input bit fl, input bit iv, input bit ordy,
                           input logic [63:0] d);
    bit push, pop;
    if (sel == 2) begin
      push = iv && (q2.size() < 2);
      pop  = ordy && (q2.size() > 0);
      if (fl) q2.delete();
      else begin
        if (pop)  void'(q2.pop_front());
        if (push) q2.push_back(d);
      end
    end else begin
      push = iv && (q4.size() < 4);
      pop  = ordy && (q4.size() > 0);
      if (fl) q4.delete();
      else begin
        if (pop)  void'(q4.pop_front());
        if (push) q4.push_back(d);
      end
    end
  endtask

  task automatic applyStimulus(input int sel, input bit fl, input bit iv, input bit ordy,
                               input logic [63:0] d);
    if (sel == 2) begin
      flush2 = fl; in_valid2 = iv; out_ready2 = ordy; in_data2 = d;
      flush4 = 0;  in_valid4 = 0;  out_ready4 = 0;
    end else begin
      flush4 = fl; in_valid4 = iv; out_ready4 = ordy; in_data4 = d;
      flush2 = 0;  in_valid2 = 0;  out_ready2 = 0;
    end
    @(posedge clk);
    modelStep(sel, fl, iv, ordy, d);
    #1;
  endtask

  task automatic checkOutput(input int sel, input string tag);
    int n;
    if (sel == 2) begin
      n = q2.size();
      checkVal({tag, " d2 count"}, 64'(count2), 64'(n));
      checkVal({tag, " d2 out_valid"}, 64'(out_valid2), 64'(n > 0));
      checkVal({tag, " d2 in_ready"}, 64'(in_ready2), 64'(n < 2));
      checkVal({tag, " d2 full"}, 64'(full2), 64'(n == 2));
      checkVal({tag, " d2 empty"}, 64'(empty2), 64'(n == 0));
      checkVal({tag, " d2 almost_full"}, 64'(af2), 64'(n >= 1));
      if (n > 0) checkVal({tag, " d2 out_data"}, out_data2, q2[0]);
    end else begin
      n = q4.size();
      checkVal({tag, " d4 count"}, 64'(count4), 64'(n));
      checkVal({tag, " d4 out_valid"}, 64'(out_valid4), 64'(n > 0));
      checkVal({tag, " d4 in_ready"}, 64'(in_ready4), 64'(n < 4));
      checkVal({tag, " d4 full"}, 64'(full4), 64'(n == 4));
      checkVal({tag, " d4 empty"}, 64'(empty4), 64'(n == 0));
      checkVal({tag, " d4 almost_full"}, 64'(af4), 64'(n >= 3));
      if (n > 0) checkVal({tag, " d4 out_data"}, out_data4, q4[0]);
    end
  endtask

  initial begin
    // Fill/backpressure vectors for DEPTH=2, derived by hand.
    vecs[0] = '{1, 0, 64'hA, 1, 1, 64'hA, 0, 1};
    vecs[1] = '{1, 0, 64'hB, 2, 1, 64'hA, 1, 0};
    vecs[2] = '{1, 1, 64'hC, 1, 1, 64'hB, 0, 1};
    vecs[3] = '{1, 0, 64'hC, 2, 1, 64'hB, 1, 0};
    vecs[4] = '{0, 1, 64'h0, 1, 1, 64'hC, 0, 1};
    vecs[5] = '{0, 1, 64'h0, 0, 0, 64'h0, 0, 1};

    flush2 = 0; in_valid2 = 0; out_ready2 = 0; in_data2 = '0;
    flush4 = 0; in_valid4 = 0; out_ready4 = 0; in_data4 = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] reset and idle");
    checkOutput(2, "reset");
    checkOutput(4, "reset");
    checkVal("reset d2 out_data", out_data2, 64'h0);
    checkVal("reset d4 out_data", out_data4, 64'h0);

    $display("[TB] single push and hold");
    applyStimulus(2, 0, 1, 0, 64'h1234);
    checkVal("push latency out_data", out_data2, 64'h1234);
    checkOutput(2, "push1");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2, 0, 0, 0, 64'h0);
      checkVal("hold out_data", out_data2, 64'h1234);
      checkOutput(2, "hold");
    end
    applyStimulus(2, 0, 0, 1, 64'h0);
    checkVal("pop empty", 64'(empty2), 64'h1);
    checkOutput(2, "pop1");

    $display("[TB] fill and backpressure table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2, 0, vecs[i].iv, vecs[i].ordy, vecs[i].data);
      checkVal($sformatf("vec%0d count", i), 64'(count2), 64'(vecs[i].exp_count));
      checkVal($sformatf("vec%0d out_valid", i), 64'(out_valid2), 64'(vecs[i].exp_valid));
      checkVal($sformatf("vec%0d full", i), 64'(full2), 64'(vecs[i].exp_full));
      checkVal($sformatf("vec%0d in_ready", i), 64'(in_ready2), 64'(vecs[i].exp_ready));
      if (vecs[i].exp_valid)
        checkVal($sformatf("vec%0d out_data", i), out_data2, vecs[i].exp_data);
      checkOutput(2, $sformatf("vec%0d", i));
    end

    $display("[TB] streaming wrap");
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(4, 0, 1, 1, 64'(i));
      checkVal("stream count", 64'(count4), 64'h1);
      checkVal("stream out_data", out_data4, 64'(i));
      checkOutput(4, "stream");
    end
    applyStimulus(4, 0, 0, 1, 64'h0);
    checkOutput(4, "stream drain");

    $display("[TB] flush with push and pop");
    for (int i = 0; i < 3; i++) applyStimulus(4, 0, 1, 0, 64'(32'h40 + i));
    checkOutput(4, "preflush");
    applyStimulus(4, 1, 1, 1, 64'h55);
    checkVal("flush count", 64'(count4), 64'h0);
    checkVal("flush out_valid", 64'(out_valid4), 64'h0);
    checkVal("flush in_ready", 64'(in_ready4), 64'h1);
    applyStimulus(4, 0, 1, 0, 64'h66);
    checkVal("after flush out_data", out_data4, 64'h66);
    checkOutput(4, "postflush");
    applyStimulus(4, 0, 0, 1, 64'h0);
    checkOutput(4, "postflush pop");

    $display("[TB] asynchronous reset mid-operation");
    for (int i = 0; i < 3; i++) applyStimulus(4, 0, 1, 0, 64'(32'h70 + i));
    checkOutput(4, "prereset");
    in_valid4 = 0; out_ready4 = 0;
    #2 resetn = 1'b0;
    #1;
    checkVal("async reset count", 64'(count4), 64'h0);
    checkVal("async reset out_valid", 64'(out_valid4), 64'h0);
    checkVal("async reset out_data", out_data4, 64'h0);
    checkVal("async reset in_ready", 64'(in_ready4), 64'h1);
    checkVal("async reset empty", 64'(empty4), 64'h1);
    checkVal("async reset almost_full", 64'(af4), 64'h0);
    q2.delete();
    q4.delete();
    @(negedge clk);
    resetn = 1'b1;
    applyStimulus(4, 0, 1, 0, 64'h77);
    checkVal("after reset out_data", out_data4, 64'h77);
    checkOutput(4, "postreset");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(2, ($urandom_range(15) == 0), 1'($urandom), 1'($urandom),
                    {$urandom, $urandom});
      checkOutput(2, "rand");
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus(4, ($urandom_range(15) == 0), 1'($urandom), 1'($urandom),
                    {$urandom, $urandom});
      checkOutput(4, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_fifo.md
# pipe_stage_fifo

Parametrised elastic pipeline register that replaces the single-entry, valid-only registers between the fetch, decode, execute and memory stages. It holds up to DEPTH packed stage records (fetch_data_t, decode_data_t, excute_data_t, memory_data_t) as opaque WIDTH-bit payloads. It uses a valid/ready handshake on both sides, so a stall in one stage is absorbed without a combinational ready chain. It provides a synchronous flush for branch/trap redirect and occupancy status for the hazard unit.

## Interface

Parameters:
- WIDTH, 64, payload width in bits. Set it to $bits of the carried stage struct; must be ≥1.
- DEPTH, 2, number of entries. Must be a power of two and ≥2.
- AF_LEVEL, DEPTH-1, the count at or above which almost_full is asserted. Range 1..DEPTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all entries.
- in_valid  in  1  upstream stage presents a record.
- in_ready  out  1  an entry is free.
- in_data  in  WIDTH  upstream record.
- out_valid  out  1  oldest record is available.
- out_ready  in  1  downstream stage consumes this cycle.
- out_data  out  WIDTH  oldest record.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.

## Operation

- Storage is a circular buffer mem[0..DEPTH-1] with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, plus a count register.
- Pointers wrap modulo DEPTH through natural overflow. This relies on DEPTH being a power of two.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- On push: mem[wr_ptr] ← in_data, then wr_ptr+1.
- On pop: rd_ptr+1.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - unchanged on push and pop together, or on neither.
- in_ready = !full. It is a function of registered state only and never depends on out_ready. When full, a pop in the same cycle does not open a slot for a push; the slot becomes available the next cycle.
- out_valid = !empty. out_data = mem[rd_ptr], a combinational read of registered storage.
- out_data must hold its value while out_valid=1 and out_ready=0.
- in_valid without in_ready: nothing is stored. The upstream stage holds its record; the block imposes no requirement on it.
- out_ready while empty: ignored. No pointer moves and count does not underflow.
- flush has priority over push and pop.
  - On a flush edge: wr_ptr, rd_ptr and count go to 0. A push or pop in the same cycle is discarded.
  - mem contents are left unchanged.
  - Next cycle: empty=1, out_valid=0, in_ready=1.
- Status outputs (full, empty, almost_full) are decoded from count only.
- Asynchronous reset (resetn=0) immediately forces:
  - wr_ptr=0, rd_ptr=0, count=0, and all mem entries=0.
  - Outputs: out_valid=0, out_data=0, in_ready=1, empty=1, full=0, almost_full=0 (because AF_LEVEL≥1).
- Reset while entries are held discards them with no drain. Normal operation resumes on the first rising edge after resetn returns to 1.

## Timing

- Push-to-output latency is 1 cycle. A record pushed at edge N is on out_data with out_valid=1 after edge N. There is no same-cycle bypass.
- Throughput is 1 record/cycle in steady state when 0<count<DEPTH with push and pop every cycle.
- in_ready deasserts in the cycle after the push that fills the buffer. It reasserts in the cycle after the first pop or flush.
- Flush and reset latency is 1 edge (flush) or immediate (reset) to empty.
- There are no combinational paths from in_valid/in_data to out_*, or from out_ready to in_ready.

## Test plan

1. Reset, then idle, with WIDTH=64, DEPTH=2. Required: out_valid=0, in_ready=1, count=0, empty=1, out_data=0.
2. Single push of 0x1234 at edge 1 with out_ready=0. Required: after edge 1, out_valid=1, out_data=0x1234, count=1. Hold out_ready=0 for 3 cycles and out_data must stay 0x1234. Then pulse out_ready: count=0 and empty=1.
3. Fill and backpressure with DEPTH=2, out_ready=0: push 0xA then 0xB. Required: full=1, in_ready=0, almost_full=1. Present 0xC with out_ready=1: the cycle pops 0xA and does not accept 0xC. Next cycle 0xC is accepted, and the output order is 0xB, then 0xC.
4. Streaming wrap with DEPTH=4, in_valid=out_ready=1 for 10 cycles, data 1..10. Required: outputs are 1..10 in order, each 1 cycle after its push; count stays 1; the pointers wrap twice without loss.
5. Flush with 3 entries held (DEPTH=4), asserting flush together with a push of 0x55 and out_ready=1. Required: the next cycle has count=0 and out_valid=0, and 0x55 is never output. A following push of 0x66 is output first.
6. Reset mid-operation with DEPTH=4 and count=3: drive resetn low between clock edges. Required: outputs go to their reset values immediately, without waiting for an edge. After release, a push of 0x77 is the first output.
